// File: rtl/clap_counter_if.sv
// Claps stream between the clap counter (master) and the light-control consumer (slave).
//
// Handshake: the master raises claps_valid with claps_data and holds both
// unchanged until a rising clock edge sees claps_valid=1 and claps_ready=1.
// That edge is the transfer. The slave may raise claps_ready at any time,
// including before claps_valid. claps_valid never depends combinationally
// on claps_ready.
interface clap_counter_if #(
    parameter int CLAPS_WIDTH = 16
) ();
    logic [CLAPS_WIDTH-1:0] claps_data;
    logic                   claps_valid;
    logic                   claps_ready;

    modport master (
        output claps_data,
        output claps_valid,
        input  claps_ready
    );

    modport slave (
        input  claps_data,
        input  claps_valid,
        output claps_ready
    );
endinterface

// File: rtl/clap_counter.sv
// Clap counter: synchronises the comparator level, counts rising edges into
// bursts with a hold-off after every accepted clap, closes a burst after a
// silence window and offers the count on the claps stream until accepted.
module clap_counter #(
    parameter int CLAPS_WIDTH    = 16,
    parameter int HOLDOFF_CYCLES = 5000000,
    parameter int WINDOW_CYCLES  = 50000000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clap_detect,
    clap_counter_if.master       claps,
    output logic                 busy,
    output logic                 claps_dropped,
    output logic [1:0]           state_dbg
);

    localparam int TIMER_MAX   = (HOLDOFF_CYCLES > WINDOW_CYCLES) ? HOLDOFF_CYCLES : WINDOW_CYCLES;
    localparam int TIMER_WIDTH = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;

    localparam logic [TIMER_WIDTH-1:0] HOLDOFF_LAST = TIMER_WIDTH'(HOLDOFF_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] WINDOW_LAST  = TIMER_WIDTH'(WINDOW_CYCLES - 1);
    localparam logic [CLAPS_WIDTH-1:0] COUNT_ONE    = CLAPS_WIDTH'(1);
    localparam logic [CLAPS_WIDTH-1:0] COUNT_MAX    = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLDOFF = 2'd1,
        WINDOW  = 2'd2,
        SEND    = 2'd3
    } state_t;

    state_t                 state;
    logic [CLAPS_WIDTH-1:0] count;
    logic [TIMER_WIDTH-1:0] timer;
    logic                   s1;
    logic                   s2;
    logic                   s2_d;
    logic                   clap_edge;

    // A level held high yields a single edge: s2 high while its delayed copy is low.
    assign clap_edge = s2 & ~s2_d;
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    // Two-flop synchroniser for the asynchronous comparator level, plus one delay stage for edge detection.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s2_d <= 1'b0;
        end else begin
            s1   <= clap_detect;
            s2   <= s1;
            s2_d <= s2;
        end
    end

    // Burst FSM: count claps, time hold-off and silence window, present the count and wait for acceptance.
    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= IDLE;
            count             <= '0;
            timer             <= '0;
            claps.claps_data  <= '0;
            claps.claps_valid <= 1'b0;
            claps_dropped     <= 1'b0;
        end else begin
            claps_dropped <= 1'b0;
            case (state)
                IDLE: begin
                    if (clap_edge) begin
                        state <= HOLDOFF;
                        count <= COUNT_ONE;
                        timer <= '0;
                    end
                end
                HOLDOFF: begin
                    // Echoes and bounce land here; they are ignored silently.
                    if (timer == HOLDOFF_LAST) begin
                        state <= WINDOW;
                        timer <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                WINDOW: begin
                    // A clap on the final silence cycle still extends the burst.
                    if (clap_edge) begin
                        state <= HOLDOFF;
                        timer <= '0;
                        if (count != COUNT_MAX) begin
                            count <= count + 1'b1;
                        end
                    end else if (timer == WINDOW_LAST) begin
                        state             <= SEND;
                        claps.claps_data  <= count;
                        claps.claps_valid <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                SEND: begin
                    // Claps while the count is pending (transfer cycle included) are discarded and flagged.
                    if (clap_edge) begin
                        claps_dropped <= 1'b1;
                    end
                    if (claps.claps_valid && claps.claps_ready) begin
                        state             <= IDLE;
                        claps.claps_valid <= 1'b0;
                        count             <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clap_counter.sv
// Testbench for clap_counter: table of burst scenarios, hand-written reset
// sequences and a randomized run, all checked each cycle against an
// arithmetic model of burst timing and a scoreboard of expected transfers.
module tb_clap_counter;

    localparam int CW = 4;
    localparam int H  = 4;
    localparam int W  = 10;
    localparam int CMAX = (1 << CW) - 1;

    // ---------------- clock / reset ----------------
    logic           clock = 1'b0;
    logic           reset;
    logic           clap_detect;
    logic           busy;
    logic           claps_dropped;
    logic [1:0]     state_dbg;

    clap_counter_if #(.CLAPS_WIDTH(CW)) claps_bus ();

    clap_counter #(
        .CLAPS_WIDTH   (CW),
        .HOLDOFF_CYCLES(H),
        .WINDOW_CYCLES (W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .clap_detect  (clap_detect),
        .claps        (claps_bus),
        .busy         (busy),
        .claps_dropped(claps_dropped),
        .state_dbg    (state_dbg)
    );

    always #5 clock = ~clock;

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [CW-1:0] exp_q[$];
    int n_transfers = 0;
    int n_drops = 0;
    logic [CW-1:0] last_data = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // ---------------- reference model ----------------
    // Burst timing is derived from the clock-edge index of the last accepted
    // clap: edges up to H cycles after it are ignored, an edge later than that
    // is a new clap, and H+W edges of quiet close the burst.
    int            m_cyc = 0;
    bit            m_samp[3] = '{0, 0, 0};   // comparator samples at edges n-1, n-2, n-3
    bit            m_in_burst = 0;
    bit            m_sending = 0;
    int            m_acc = 0;
    int            m_cnt = 0;
    logic [CW-1:0] m_data = '0;
    bit            m_dropped = 0;

    task automatic model_step();
        bit e;
        e = m_samp[1] && !m_samp[2];
        m_cyc++;
        if (reset) begin
            m_samp     = '{0, 0, 0};
            m_in_burst = 0;
            m_sending  = 0;
            m_cnt      = 0;
            m_data     = '0;
            m_dropped  = 0;
            return;
        end
        m_samp[2] = m_samp[1];
        m_samp[1] = m_samp[0];
        m_samp[0] = (clap_detect === 1'b1);
        m_dropped = 0;
        if (m_sending) begin
            if (e) m_dropped = 1;
            if (claps_bus.claps_ready === 1'b1) begin
                exp_q.push_back(m_data);
                m_sending = 0;
                m_cnt     = 0;
            end
        end else if (m_in_burst) begin
            if (m_cyc - m_acc <= H) begin
                m_dropped = 0;  // hold-off: nothing changes
            end else if (e) begin
                m_acc = m_cyc;
                m_cnt = (m_cnt >= CMAX) ? CMAX : m_cnt + 1;
            end else if (m_cyc - m_acc == H + W) begin
                m_in_burst = 0;
                m_sending  = 1;
                m_data     = CW'(m_cnt);
            end
        end else if (e) begin
            m_in_burst = 1;
            m_acc      = m_cyc;
            m_cnt      = 1;
        end
    endtask

    // ---------------- driver: one clock cycle ----------------
    task automatic tick();
        logic          tr;
        logic [CW-1:0] trd;
        tr  = claps_bus.claps_valid & claps_bus.claps_ready & ~reset;
        trd = claps_bus.claps_data;
        @(posedge clock);
        model_step();
        #1;
        if (tr === 1'b1) begin
            n_transfers++;
            last_data = trd;
            if (exp_q.size() == 0) fail_now("unexpected_transfer");
            else check("transfer_data", trd, exp_q.pop_front());
        end
        if (claps_dropped === 1'b1) n_drops++;
        check("claps_valid", claps_bus.claps_valid, m_sending);
        check("busy", busy, m_in_burst | m_sending);
        check("claps_dropped", claps_dropped, m_dropped);
        check("claps_data", claps_bus.claps_data, m_data);
    endtask

    // ---------------- table-driven burst scenarios ----------------
    typedef struct {
        int n_claps;          // pulses in the burst
        int gap;              // cycles between pulse starts
        int hi;               // cycles each pulse stays high
        int hold;             // cycles ready stays low after valid rises (0: ready always high)
        bit drop_clap;        // add a clap while the count is pending
        int exp_data;
        int exp_first_valid;  // cycle index after which claps_valid is first seen
        int exp_drops;
    } vec_t;

    vec_t vecs[10];

    task automatic run_vec(input vec_t v, input string tag);
        int t;
        int valid_t;
        int tr0;
        int dr0;
        int sched_end;
        bit done;
        logic cd;
        tr0       = n_transfers;
        dr0       = n_drops;
        valid_t   = -1;
        sched_end = (v.n_claps - 1) * v.gap + v.hi;
        done      = 0;
        for (t = 0; t < 800 && !done; t++) begin
            cd = 1'b0;
            for (int k = 0; k < v.n_claps; k++) begin
                if (t >= k * v.gap && t < k * v.gap + v.hi) cd = 1'b1;
            end
            if (v.drop_clap && valid_t >= 0 && t >= valid_t + 5 && t < valid_t + 7) cd = 1'b1;
            clap_detect = cd;
            claps_bus.claps_ready = (v.hold == 0) || (valid_t >= 0 && t >= valid_t + v.hold);
            tick();
            if (valid_t < 0 && claps_bus.claps_valid === 1'b1) valid_t = t;
            if (n_transfers > tr0 && t >= sched_end + 3 && busy === 1'b0) done = 1;
        end
        clap_detect = 1'b0;
        claps_bus.claps_ready = 1'b1;
        if (!done) fail_now({tag, "_timeout"});
        check({tag, "_transfers"}, n_transfers - tr0, 1);
        check({tag, "_data"}, last_data, v.exp_data);
        check({tag, "_first_valid"}, valid_t, v.exp_first_valid);
        check({tag, "_drops"}, n_drops - dr0, v.exp_drops);
        repeat (4) tick();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int tr0;
        int lvl_left;
        bit seen;

        vecs[0] = '{1,  0, 3,  0, 0,  1,  16, 0};  // single clap
        vecs[1] = '{2,  8, 3,  0, 0,  2,  24, 0};  // second clap in window
        vecs[2] = '{2,  3, 1,  0, 0,  1,  16, 0};  // second clap deep in hold-off
        vecs[3] = '{2,  4, 1,  0, 0,  1,  16, 0};  // second clap on last hold-off cycle
        vecs[4] = '{2,  5, 1,  0, 0,  2,  21, 0};  // second clap on first window cycle
        vecs[5] = '{20, 6, 3,  0, 0, 15, 130, 0};  // saturation
        vecs[6] = '{1,  0, 3, 30, 1,  1,  16, 1};  // backpressure with dropped clap
        vecs[7] = '{2, 14, 3,  0, 0,  2,  30, 0};  // clap collides with window timeout
        vecs[8] = '{2, 15, 3,  0, 0,  1,  16, 1};  // clap on the transfer edge is dropped
        vecs[9] = '{3, 14, 3,  0, 0,  3,  44, 0};  // repeated timeout collisions

        reset = 1'b1;
        clap_detect = 1'b0;
        claps_bus.claps_ready = 1'b1;
        repeat (3) tick();
        check("reset_valid", claps_bus.claps_valid, 0);
        check("reset_data", claps_bus.claps_data, 0);
        check("reset_busy", busy, 0);
        check("reset_dropped", claps_dropped, 0);
        reset = 1'b0;
        repeat (3) tick();

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset during WINDOW after two accepted claps.
        for (int t = 0; t < 17; t++) begin
            clap_detect = (t < 3) || (t >= 8 && t < 11);
            tick();
        end
        clap_detect = 1'b0;
        check("rstwin_busy_before", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstwin_busy", busy, 0);
        check("rstwin_valid", claps_bus.claps_valid, 0);
        tr0 = n_transfers;
        repeat (30) tick();
        check("rstwin_no_transfer", n_transfers - tr0, 0);
        run_vec(vecs[0], "rstwin_after");

        // Reset while the count is pending in SEND.
        claps_bus.claps_ready = 1'b0;
        clap_detect = 1'b1;
        repeat (3) tick();
        clap_detect = 1'b0;
        seen = 0;
        for (int t = 0; t < 40 && !seen; t++) begin
            tick();
            if (claps_bus.claps_valid === 1'b1) seen = 1;
        end
        if (!seen) fail_now("rstsend_valid_timeout");
        repeat (5) tick();
        check("rstsend_valid_held", claps_bus.claps_valid, 1);
        check("rstsend_data_held", claps_bus.claps_data, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstsend_busy", busy, 0);
        check("rstsend_valid", claps_bus.claps_valid, 0);
        tr0 = n_transfers;
        claps_bus.claps_ready = 1'b1;
        repeat (20) tick();
        check("rstsend_no_transfer", n_transfers - tr0, 0);
        run_vec(vecs[0], "rstsend_after");

        // Randomized comparator levels, ready and occasional reset.
        lvl_left = 0;
        for (int i = 0; i < 4000; i++) begin
            if (lvl_left == 0) begin
                clap_detect = ~clap_detect;
                lvl_left = $urandom_range(1, 14);
            end
            lvl_left--;
            claps_bus.claps_ready = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 599) == 0);
            tick();
        end
        reset = 1'b0;
        clap_detect = 1'b0;
        claps_bus.claps_ready = 1'b1;
        repeat (40) tick();
        check("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog: the run must end on its own.
    initial begin
        #5ms;
        $display("FAIL watchdog_timeout (t=%0t)", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
